// File: rtl/weight_sram_loader.sv
// Write-side engine for the int8 weight SRAM: takes a valid/ready word stream and scatters it
// into the lane-interleaved layout expected by the 64-lane weight read port.
module weight_sram_loader #(
  parameter int unsigned SIZE   = 4096,
  parameter int unsigned ADDR_W = $clog2(SIZE),
  parameter int unsigned TILE_W = ADDR_W - 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [TILE_W-1:0] base_tile_i,
  input  logic [ADDR_W:0]   num_words_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              in_valid_i,
  input  logic [31:0]       in_data_i,
  output logic              in_ready_o,
  output logic              sram_en_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_di_o
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_LAST = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    num_q;
  logic [TILE_W-1:0]   base_q;
  logic                busy_q;
  logic                ready_q;
  logic                done_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   di_q;

  logic [TILE_W-1:0]   tile_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                last_d;

  // Word g of the job goes to {tile, j[2:0], h, j[5:3]} with w = g[6:0], h = w[6], j = w[5:0].
  always_comb begin
    tile_d = base_q + cnt_q[ADDR_W-1:7];
    addr_d = {tile_d, cnt_q[2:0], cnt_q[6], cnt_q[5:3]};
    last_d = (cnt_q == (num_q - CNT_W'(1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      base_q  <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      di_q    <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // An empty job completes at once without entering LOAD.
          if (start_i) begin
            if (num_words_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
              busy_q  <= 1'b1;
              ready_q <= 1'b1;
              num_q   <= num_words_i;
              base_q  <= base_tile_i;
              cnt_q   <= '0;
            end
          end
        end
        ST_LOAD: begin
          if (in_valid_i) begin
            we_q   <= 1'b1;
            addr_q <= addr_d;
            di_q   <= in_data_i;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (last_d) begin
              state_q <= ST_LAST;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_LAST: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign in_ready_o  = ready_q;
  assign sram_en_o   = 1'b0;
  assign sram_we_o   = we_q;
  assign sram_addr_o = addr_q;
  assign sram_di_o   = di_q;

endmodule

// File: tb/tb_weight_sram_loader.sv
// Self-checking bench for weight_sram_loader: randomized streams checked against an arithmetic
// address/ordering model and a shadow SRAM built from the observed writes.
module tb_weight_sram_loader;

  localparam int unsigned SIZE   = 4096;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned TILE_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic [TILE_W-1:0] base_tile_i = '0;
  logic [ADDR_W:0]   num_words_i = '0;
  logic              busy_o;
  logic              done_o;
  logic              in_valid_i = 1'b0;
  logic [31:0]       in_data_i = '0;
  logic              in_ready_o;
  logic              sram_en_o;
  logic              sram_we_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [31:0]       sram_di_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] dut_mem   [SIZE];
  logic [31:0] job_words [SIZE];

  weight_sram_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .base_tile_i(base_tile_i),
    .num_words_i(num_words_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_ready_o (in_ready_o),
    .sram_en_o  (sram_en_o),
    .sram_we_o  (sram_we_o),
    .sram_addr_o(sram_addr_o),
    .sram_di_o  (sram_di_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Destination of stream word g, written out from the layout description in plain arithmetic.
  function automatic int exp_addr(input int base, input int g);
    int tile, w, h, j;
    tile = (base + g / 128) % (SIZE / 128);
    w    = g % 128;
    h    = w / 64;
    j    = w % 64;
    return tile * 128 + (j % 8) * 16 + h * 8 + j / 8;
  endfunction

  function automatic bit valid_pattern(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc % 6) == 0) || ((cyc % 6) == 3) || ((cyc % 6) == 4);
      default: return ($urandom % 4) != 0;
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},  64'(busy_o),      64'd0);
    chk({tag, "_done"},  64'(done_o),      64'd0);
    chk({tag, "_ready"}, 64'(in_ready_o),  64'd0);
    chk({tag, "_we"},    64'(sram_we_o),   64'd0);
  endtask

  // Runs one job; mode 0 streams g as data. stray_at issues start mid-job; abort_at stops after that many writes.
  task automatic run_job(input int base, input int n, input int mode, input int stray_at,
                         input int abort_at);
    int  sent, got, cyc, budget;
    bit  prev_x, done_seen, v;
    for (int g = 0; g < n; g++) job_words[g] = (mode == 0) ? 32'(g) : $urandom;
    sent = 0; got = 0; cyc = 0; prev_x = 1'b0; done_seen = 1'b0;
    budget = n * 8 + 20;
    @(negedge clk);
    start_i     = 1'b1;
    base_tile_i = TILE_W'(base);
    num_words_i = (ADDR_W + 1)'(n);
    @(negedge clk);
    start_i     = 1'b0;
    base_tile_i = TILE_W'($urandom);
    num_words_i = (ADDR_W + 1)'($urandom_range(1, SIZE));
    while (cyc < budget) begin
      chk("we_follows_xfer", 64'(sram_we_o), 64'(prev_x));
      chk("busy_in_job", 64'(busy_o), 64'd1);
      chk("en_tied_low", 64'(sram_en_o), 64'd0);
      if (sram_we_o) begin
        if (got < n) begin
          chk("wr_addr", 64'(sram_addr_o), 64'(exp_addr(base, got)));
          chk("wr_data", 64'(sram_di_o), 64'(job_words[got]));
        end
        dut_mem[sram_addr_o] = sram_di_o;
        got++;
      end
      if (done_o) begin
        done_seen = 1'b1;
        chk("done_at_last_write", 64'(got), 64'(n));
        chk("done_with_we", 64'(sram_we_o), 64'd1);
        chk("ready_low_in_last", 64'(in_ready_o), 64'd0);
        break;
      end
      if (abort_at > 0 && got == abort_at) begin
        in_valid_i = 1'b0;
        return;
      end
      v          = valid_pattern(mode, cyc) && (sent < n);
      in_valid_i = v;
      in_data_i  = (sent < n) ? job_words[sent] : $urandom;
      start_i    = (cyc == stray_at);
      prev_x     = v && in_ready_o;
      if (prev_x) sent++;
      cyc++;
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    start_i    = 1'b0;
    if (!done_seen) chk("job_timeout", 64'd0, 64'd1);
    chk("writes_total", 64'(got), 64'(n));
    chk("words_sent", 64'(sent), 64'(n));
    @(negedge clk);
    check_idle_outputs("after_job");
  endtask

  initial begin
    for (int a = 0; a < SIZE; a++) dut_mem[a] = 32'hDEAD_BEEF;

    // Reset state
    #12;
    check_idle_outputs("reset");
    chk("reset_addr", 64'(sram_addr_o), 64'd0);
    chk("reset_di",   64'(sram_di_o),   64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single full tile, data = index, no backpressure
    run_job(0, 128, 0, -1, 0);
    chk("t1_g0",   64'(dut_mem[0]),   64'd0);
    chk("t1_g1",   64'(dut_mem[16]),  64'd1);
    chk("t1_g8",   64'(dut_mem[1]),   64'd8);
    chk("t1_g64",  64'(dut_mem[8]),   64'd64);
    chk("t1_g127", 64'(dut_mem[127]), 64'd127);

    // 64-lane readback: lane j of read {0,h,i} is byte i of word h*64+j
    for (int h = 0; h < 2; h++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 64; j++) begin
          logic [31:0] word;
          logic [31:0] ref_word;
          word     = dut_mem[(j % 8) * 16 + h * 8 + j / 8];
          ref_word = 32'(h * 64 + j);
          chk("t2_lane", 64'(word[8*i +: 8]), 64'(ref_word[8*i +: 8]));
        end

    // Backpressure pattern 1,0,0,1,1,0
    run_job(3, 10, 1, -1, 0);

    // Tile wrap from the last tile
    run_job(31, 256, 2, -1, 0);
    chk("t4_first", 64'(dut_mem[3968]), 64'(job_words[0]));
    chk("t4_127",   64'(dut_mem[4095]), 64'(job_words[127]));
    chk("t4_128",   64'(dut_mem[0]),    64'(job_words[128]));
    chk("t4_255",   64'(dut_mem[127]),  64'(job_words[255]));

    // Empty job
    @(negedge clk);
    start_i     = 1'b1;
    num_words_i = '0;
    base_tile_i = 5'd7;
    @(negedge clk);
    start_i = 1'b0;
    chk("t5_done_pulse", 64'(done_o), 64'd1);
    chk("t5_busy",       64'(busy_o), 64'd0);
    chk("t5_ready",      64'(in_ready_o), 64'd0);
    chk("t5_we",         64'(sram_we_o), 64'd0);
    @(negedge clk);
    check_idle_outputs("t5_after");

    // Start during LOAD is ignored
    run_job(9, 20, 1, 5, 0);

    // Reset mid-job
    run_job(0, 128, 0, -1, 40);
    rst = 1'b1;
    #1;
    check_idle_outputs("t6_rst");
    chk("t6_addr", 64'(sram_addr_o), 64'd0);
    chk("t6_di",   64'(sram_di_o),   64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_idle_outputs("t6_hold");
    end
    rst = 1'b0;
    run_job(2, 3, 2, -1, 0);

    // Randomized jobs, including one full-SRAM fill
    for (int r = 0; r < 6; r++)
      run_job(int'($urandom_range(0, 31)), int'($urandom_range(1, 300)), int'($urandom_range(0, 2)),
              (r == 2) ? 7 : -1, 0);
    run_job(int'($urandom_range(0, 31)), SIZE, 0, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
